// File: rtl/irq_ctrl_pkg.sv
// ============================================================================
// Module      : irq_ctrl_pkg
// Description : Shared constants and state encoding for the interrupt controller
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package irq_ctrl_pkg;

    localparam logic [1:0] IRQ_IER   = 2'd0;
    localparam logic [1:0] IRQ_MODE  = 2'd1;
    localparam logic [1:0] IRQ_PEND  = 2'd2;
    localparam logic [1:0] IRQ_CLAIM = 2'd3;

    localparam int GE_BIT   = 31;
    localparam int BUSY_BIT = 31;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_COOL  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/irq_src.sv
// ============================================================================
// Module      : irq_src
// Description : Per-source input synchroniser, edge detector and sticky pend bit
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_src
    import irq_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic irq,
    input  logic mode,
    input  logic clr,
    output logic pend
);

    logic src_q;
    logic src_q2;
    logic sticky;
    logic rise;

    assign rise = src_q & ~src_q2;

    // A new edge in the same cycle as a clear keeps the bit set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_q  <= 1'b0;
            src_q2 <= 1'b0;
            sticky <= 1'b0;
        end else begin
            src_q  <= irq;
            src_q2 <= src_q;
            if (mode && rise)
                sticky <= 1'b1;
            else if (clr)
                sticky <= 1'b0;
        end
    end

    assign pend = sticky | (~mode & src_q);

endmodule

`default_nettype wire

// File: rtl/irq_ctrl.sv
// ============================================================================
// Module      : irq_ctrl
// Description : Fixed-priority programmable interrupt controller, Bridge slave
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC    = 6,
    parameter int ID_W     = 3,
    parameter int COOLDOWN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_in,
    input  logic [3:0]       Addr_In,
    input  logic             WE,
    input  logic [31:0]      Data_In,
    output logic [31:0]      Data_Out,
    output logic [N_SRC-1:0] irq_out
);

    localparam logic [2:0] COOL_LOAD = 3'(COOLDOWN - 1);

    state_t           state;
    state_t           state_nx;
    logic [N_SRC-1:0] mask;
    logic             ge;
    logic [N_SRC-1:0] mode;
    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] pend_clr;
    logic [N_SRC-1:0] eligible;
    logic [ID_W-1:0]  cur_id;
    logic [ID_W-1:0]  first_id;
    logic             found;
    logic [2:0]       cool_cnt;
    logic [N_SRC-1:0] irq_q;
    logic [1:0]       reg_idx;
    logic             eoi;
    logic             unused_bits;

    assign reg_idx     = Addr_In[3:2];
    assign unused_bits = ^{Addr_In[1:0], Data_In[30:N_SRC]};

    assign eoi = WE && (reg_idx == IRQ_CLAIM) && (state == ST_GRANT)
              && (Data_In[ID_W-1:0] == cur_id);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask <= '0;
            ge   <= 1'b0;
            mode <= '0;
        end else if (WE) begin
            if (reg_idx == IRQ_IER) begin
                mask <= Data_In[N_SRC-1:0];
                ge   <= Data_In[GE_BIT];
            end
            if (reg_idx == IRQ_MODE)
                mode <= Data_In[N_SRC-1:0];
        end
    end

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        assign pend_clr[i] = (WE && (reg_idx == IRQ_PEND) && Data_In[i])
                           || (eoi && (cur_id == ID_W'(i)));

        irq_src u_src (
            .clk   (clk),
            .reset (reset),
            .irq   (irq_in[i]),
            .mode  (mode[i]),
            .clr   (pend_clr[i]),
            .pend  (pend[i])
        );
    end

    assign eligible = pend & mask & {N_SRC{ge}};

    // Lowest index wins: scan downwards so the last hit is the smallest.
    always_comb begin
        found    = 1'b0;
        first_id = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                found    = 1'b1;
                first_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (found) state_nx = ST_GRANT;
            ST_GRANT: begin
                if (eoi)
                    state_nx = ST_COOL;
                else if (!mask[cur_id] || !ge)
                    state_nx = ST_IDLE;
            end
            ST_COOL:  if (cool_cnt == 3'd0) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // irq_out is asserted only once GRANT has been held for a full cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cur_id   <= '0;
            cool_cnt <= 3'd0;
            irq_q    <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && found)
                cur_id <= first_id;
            if (state == ST_GRANT && eoi)
                cool_cnt <= COOL_LOAD;
            else if (state == ST_COOL && cool_cnt != 3'd0)
                cool_cnt <= cool_cnt - 3'd1;
            if (state == ST_GRANT && state_nx == ST_GRANT)
                irq_q <= N_SRC'(1) << cur_id;
            else
                irq_q <= '0;
        end
    end

    assign irq_out = irq_q;

    always_comb begin
        Data_Out = '0;
        case (reg_idx)
            IRQ_IER: begin
                Data_Out[N_SRC-1:0] = mask;
                Data_Out[GE_BIT]    = ge;
            end
            IRQ_MODE:  Data_Out[N_SRC-1:0] = mode;
            IRQ_PEND:  Data_Out[N_SRC-1:0] = pend;
            IRQ_CLAIM: begin
                Data_Out[ID_W-1:0] = cur_id;
                Data_Out[BUSY_BIT] = (state == ST_GRANT);
            end
            default:   Data_Out = '0;
        endcase
    end

endmodule

`default_nettype wire
